// File: rtl/snake_pkg.sv
// Direction encoding shared by the direction controller, game engine and renderer.
// Headings are 2-bit; the reverse of a heading is the heading with bit 1 flipped.
package snake_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'd0;
  localparam dir_t DIR_RIGHT = 2'd1;
  localparam dir_t DIR_DOWN  = 2'd2;
  localparam dir_t DIR_LEFT  = 2'd3;

  function automatic dir_t opposite(input dir_t dir);
    return dir ^ 2'b10;
  endfunction

endpackage

// File: rtl/rise_edge_detect.sv
// Rising-edge detector: pulse is combinational in the cycle the input rises.
// The previous-level flop resets to 1 so a level held through reset never fires.
module rise_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic pulse
);

  logic prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prev_q <= 1'b1;
    else        prev_q <= in;
  end

  assign pulse = in & ~prev_q;

endmodule

// File: rtl/snake_direction_ctrl.sv
// Snake heading controller: edge-detects buttons, filters no-op/reversal turns, buffers up to 2 turns.
// Push visible next cycle; a tick pops one turn into direction next cycle; a full queue drops and pulses.
module snake_direction_ctrl
  import snake_pkg::*;
#(
  parameter dir_t RESET_DIR = DIR_RIGHT,
  parameter int   QDEPTH    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       game_tick,
  input  logic       restart,
  output dir_t       direction,
  output logic       turn_pulse,
  output logic [1:0] queue_count,
  output logic       drop_pulse
);

  localparam logic [1:0] QFULL = 2'(QDEPTH);

  logic press_up, press_down, press_left, press_right;

  rise_edge_detect u_up    (.clk(clk), .reset(reset), .in(btn_up),    .pulse(press_up));
  rise_edge_detect u_down  (.clk(clk), .reset(reset), .in(btn_down),  .pulse(press_down));
  rise_edge_detect u_left  (.clk(clk), .reset(reset), .in(btn_left),  .pulse(press_left));
  rise_edge_detect u_right (.clk(clk), .reset(reset), .in(btn_right), .pulse(press_right));

  dir_t       dir_q, dir_d;
  dir_t [1:0] q_q, q_d;
  logic       head_q, head_d;
  logic [1:0] count_q, count_d;
  logic       turn_q, turn_d;
  logic       drop_q, drop_d;

  logic req_vld, turn_vld, pop, push, drop;
  dir_t req_dir, ref_dir;
  logic tail_idx, wr_idx;

  always_comb begin
    req_vld = 1'b1;
    req_dir = DIR_UP;
    if (press_up)         req_dir = DIR_UP;
    else if (press_down)  req_dir = DIR_DOWN;
    else if (press_left)  req_dir = DIR_LEFT;
    else if (press_right) req_dir = DIR_RIGHT;
    else                  req_vld = 1'b0;
  end

  // Last queued entry sits at head+count-1; the next free slot at head+count.
  // With a full queue and a pop, the free slot is the head being popped.
  assign tail_idx = head_q ^ (count_q == QFULL);
  assign wr_idx   = head_q ^ count_q[0];
  assign ref_dir  = (count_q != 2'd0) ? q_q[tail_idx] : dir_q;

  assign turn_vld = req_vld && (req_dir != ref_dir) && (req_dir != opposite(ref_dir));
  assign pop      = game_tick && (count_q != 2'd0);
  assign push     = turn_vld && ((count_q != QFULL) || pop);
  assign drop     = turn_vld && (count_q == QFULL) && !pop;

  always_comb begin
    dir_d   = dir_q;
    q_d     = q_q;
    head_d  = head_q;
    count_d = count_q;
    turn_d  = 1'b0;
    drop_d  = 1'b0;
    if (restart) begin
      dir_d   = RESET_DIR;
      head_d  = 1'b0;
      count_d = 2'd0;
    end else begin
      if (pop) begin
        dir_d  = q_q[head_q];
        turn_d = (q_q[head_q] != dir_q);
        head_d = ~head_q;
      end
      if (push) q_d[wr_idx] = req_dir;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
      drop_d  = drop;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dir_q   <= RESET_DIR;
      q_q     <= {RESET_DIR, RESET_DIR};
      head_q  <= 1'b0;
      count_q <= 2'd0;
      turn_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      dir_q   <= dir_d;
      q_q     <= q_d;
      head_q  <= head_d;
      count_q <= count_d;
      turn_q  <= turn_d;
      drop_q  <= drop_d;
    end
  end

  assign direction   = dir_q;
  assign turn_pulse  = turn_q;
  assign queue_count = count_q;
  assign drop_pulse  = drop_q;

endmodule

// File: tb/tb_snake_direction_ctrl.sv
// Directed vector bench for snake_direction_ctrl: one table row per clock, plus reset corner sequences.
module tb_snake_direction_ctrl;
  import snake_pkg::*;

  typedef struct {
    logic [3:0] btn;   // {up, down, left, right} levels
    logic       tick;
    logic       rst;
    logic [1:0] dir;
    logic [1:0] cnt;
    logic       turn;
    logic       drop;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic       game_tick = 1'b0, restart = 1'b0;
  dir_t       direction;
  logic       turn_pulse, drop_pulse;
  logic [1:0] queue_count;

  int checks = 0;
  int errors = 0;
  vec_t vq[$];

  snake_direction_ctrl #(.RESET_DIR(DIR_RIGHT), .QDEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .game_tick(game_tick), .restart(restart),
    .direction(direction), .turn_pulse(turn_pulse),
    .queue_count(queue_count), .drop_pulse(drop_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int d, input int c, input int t, input int dr);
    chk({tag, " direction"},   int'(direction),   d);
    chk({tag, " queue_count"}, int'(queue_count), c);
    chk({tag, " turn_pulse"},  int'(turn_pulse),  t);
    chk({tag, " drop_pulse"},  int'(drop_pulse),  dr);
  endtask

  task automatic add(input logic [3:0] b, input logic tk, input logic rs,
                     input logic [1:0] d, input logic [1:0] c, input logic t, input logic dr);
    vec_t v;
    v.btn = b; v.tick = tk; v.rst = rs; v.dir = d; v.cnt = c; v.turn = t; v.drop = dr;
    vq.push_back(v);
  endtask

  task automatic drive(input logic [3:0] b, input logic tk, input logic rs);
    {btn_up, btn_down, btn_left, btn_right} = b;
    game_tick = tk;
    restart   = rs;
  endtask

  initial begin
    //   btn      tick rst  dir  cnt turn drop
    add(4'b0000, 0, 0, 2'd1, 2'd0, 0, 0); // idle
    add(4'b0000, 1, 0, 2'd1, 2'd0, 0, 0); // tick on empty queue holds
    add(4'b1000, 0, 0, 2'd1, 2'd1, 0, 0); // UP queued
    add(4'b0000, 1, 0, 2'd0, 2'd0, 1, 0); // UP applied
    add(4'b0000, 0, 0, 2'd0, 2'd0, 0, 0); // turn pulse one cycle only
    add(4'b0100, 0, 0, 2'd0, 2'd0, 0, 0); // DOWN is a reversal
    add(4'b0000, 1, 0, 2'd0, 2'd0, 0, 0);
    add(4'b0000, 0, 1, 2'd1, 2'd0, 0, 0); // restart
    add(4'b1000, 0, 0, 2'd1, 2'd1, 0, 0); // UP
    add(4'b0000, 0, 0, 2'd1, 2'd1, 0, 0);
    add(4'b0010, 0, 0, 2'd1, 2'd2, 0, 0); // LEFT filtered against queued UP
    add(4'b0000, 1, 0, 2'd0, 2'd1, 1, 0);
    add(4'b0000, 1, 0, 2'd3, 2'd0, 1, 0);
    add(4'b0000, 0, 1, 2'd1, 2'd0, 0, 0); // restart
    add(4'b1000, 0, 0, 2'd1, 2'd1, 0, 0); // UP
    add(4'b0010, 0, 0, 2'd1, 2'd2, 0, 0); // LEFT
    add(4'b0100, 0, 0, 2'd1, 2'd2, 0, 1); // DOWN dropped, queue full
    add(4'b0000, 0, 0, 2'd1, 2'd2, 0, 0);
    add(4'b0100, 1, 0, 2'd0, 2'd2, 1, 0); // DOWN with pop: accepted
    add(4'b0000, 1, 0, 2'd3, 2'd1, 1, 0);
    add(4'b0000, 1, 0, 2'd2, 2'd0, 1, 0);
    add(4'b0000, 0, 1, 2'd1, 2'd0, 0, 0); // restart
    add(4'b1010, 0, 0, 2'd1, 2'd1, 0, 0); // UP+LEFT together: UP wins
    add(4'b0000, 1, 0, 2'd0, 2'd0, 1, 0);
    add(4'b0000, 0, 1, 2'd1, 2'd0, 0, 0); // restart
    add(4'b1000, 0, 0, 2'd1, 2'd1, 0, 0);
    add(4'b0010, 0, 0, 2'd1, 2'd2, 0, 0);
    add(4'b0000, 1, 1, 2'd1, 2'd0, 0, 0); // restart beats tick
    add(4'b0000, 1, 0, 2'd1, 2'd0, 0, 0);
    add(4'b1000, 1, 0, 2'd1, 2'd1, 0, 0); // press+tick, empty: not applied yet
    add(4'b0000, 1, 0, 2'd0, 2'd0, 1, 0);
    add(4'b0010, 0, 0, 2'd0, 2'd1, 0, 0); // LEFT
    add(4'b0001, 1, 0, 2'd3, 2'd0, 1, 0); // RIGHT vs popped LEFT: reversal
    add(4'b1000, 1, 0, 2'd3, 2'd1, 0, 0);
    add(4'b0000, 1, 0, 2'd0, 2'd0, 1, 0);
    add(4'b0010, 0, 1, 2'd1, 2'd0, 0, 0); // restart beats press
    add(4'b0000, 1, 0, 2'd1, 2'd0, 0, 0);

    drive(4'b0000, 0, 0);
    repeat (2) @(posedge clk);
    #1 chk_all("reset", 1, 0, 0, 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1 chk_all("post_reset", 1, 0, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk) drive(vq[i].btn, vq[i].tick, vq[i].rst);
      @(posedge clk); #1
      chk_all($sformatf("vec%0d", i), int'(vq[i].dir), int'(vq[i].cnt),
              int'(vq[i].turn), int'(vq[i].drop));
    end

    // UP held across reset release must not be seen as a press.
    @(negedge clk) begin drive(4'b1000, 0, 0); reset = 1'b0; end
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_all("held_up", 1, 0, 0, 0);
    @(negedge clk) drive(4'b0000, 0, 0);
    @(negedge clk) drive(4'b1000, 0, 0);
    @(posedge clk); #1 chk("held_up repress queue_count", int'(queue_count), 1);
    @(negedge clk) drive(4'b0010, 0, 0);
    @(posedge clk); #1 chk("fill queue_count", int'(queue_count), 2);
    @(negedge clk) drive(4'b0100, 0, 0);
    @(posedge clk); #1 chk("fill drop_pulse", int'(drop_pulse), 1);

    // Asynchronous reset mid-operation clears everything without a clock edge.
    #1 reset = 1'b0;
    #1 chk_all("async_reset", 1, 0, 0, 0);
    @(negedge clk) drive(4'b0000, 0, 0);
    reset = 1'b1;
    @(posedge clk); #1 chk_all("after_async_reset", 1, 0, 0, 0);
    @(negedge clk) drive(4'b0000, 1, 0);
    @(posedge clk); #1 chk_all("tick_after_reset", 1, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
